// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer, the game controller and the display.
// The state encoding and default limits live here.
package round_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam int unsigned HALF_CYC_DEF = 100_000_000;
    localparam int unsigned MAX_HALVES   = 30;
    localparam int unsigned WRONG_LIMIT  = 3;
    localparam int unsigned CNT_W        = 32;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned WRONG_W      = 3;

endpackage

// File: rtl/round_timer_if.sv
// Control and status bundle between the game controller and the round timer.
// The controller is the master and drives the control inputs.
interface round_timer_if #(
    parameter int unsigned CNT_W   = round_timer_pkg::CNT_W,
    parameter int unsigned IDX_W   = round_timer_pkg::IDX_W,
    parameter int unsigned WRONG_W = round_timer_pkg::WRONG_W
);

    logic               enable;
    logic               clear;
    logic [CNT_W-1:0]   half_cyc;
    logic [WRONG_W-1:0] wrong_cnt;
    logic               clk_slow;
    logic               tick;
    logic [IDX_W-1:0]   half_idx;
    logic               running;
    logic               done;

    modport master (
        output enable,
        output clear,
        output half_cyc,
        output wrong_cnt,
        input  clk_slow,
        input  tick,
        input  half_idx,
        input  running,
        input  done
    );

    modport slave (
        input  enable,
        input  clear,
        input  half_cyc,
        input  wrong_cnt,
        output clk_slow,
        output tick,
        output half_idx,
        output running,
        output done
    );

endinterface

// File: rtl/round_timer_tick_gen.sv
// Loadable half-period counter with a terminal-count flag.
// The length is re-latched every time the count wraps.
module round_timer_tick_gen #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] len_in,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len;

    assign tc = (cnt == len - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            cnt <= '0;
            len <= len_in;
        end else if (en) begin
            if (tc) begin
                cnt <= '0;
                len <= len_in;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/round_timer.sv
// Round timer: slow clock, toggle tick and half-period index with
// pause, restart and stop on round end or on too many wrong answers.
module round_timer #(
    parameter int unsigned HALF_CYC_DEF = round_timer_pkg::HALF_CYC_DEF,
    parameter int unsigned CNT_W        = round_timer_pkg::CNT_W,
    parameter int unsigned MAX_HALVES   = round_timer_pkg::MAX_HALVES,
    parameter int unsigned IDX_W        = round_timer_pkg::IDX_W,
    parameter int unsigned WRONG_W      = round_timer_pkg::WRONG_W,
    parameter int unsigned WRONG_LIMIT  = round_timer_pkg::WRONG_LIMIT
) (
    input logic          clk,
    input logic          rst_n,
    round_timer_if.slave bus
);

    import round_timer_pkg::*;

    state_t           state_q;
    state_t           state_nx;
    logic             clk_slow_q;
    logic             clk_slow_nx;
    logic             tick_q;
    logic             tick_nx;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nx;
    logic [CNT_W-1:0] len_in;
    logic             wrong;
    logic             last;
    logic             tc;
    logic             tg_clr;
    logic             tg_load;
    logic             tg_en;

    assign wrong  = (bus.wrong_cnt >= WRONG_W'(WRONG_LIMIT));
    assign last   = (idx_q == IDX_W'(MAX_HALVES - 1));
    assign len_in = (bus.half_cyc == '0) ? CNT_W'(HALF_CYC_DEF)
                                         : bus.half_cyc;
    assign tg_clr = !rst_n || bus.clear;

    round_timer_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .clr    (tg_clr),
        .load   (tg_load),
        .en     (tg_en),
        .len_in (len_in),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            state_q    <= IDLE;
            clk_slow_q <= 1'b0;
            tick_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_nx;
            clk_slow_q <= clk_slow_nx;
            tick_q     <= tick_nx;
            idx_q      <= idx_nx;
        end
    end

    // Every cycle spent in RUN counts; enable only picks the next state.
    always_comb begin
        state_nx    = state_q;
        clk_slow_nx = clk_slow_q;
        tick_nx     = 1'b0;
        idx_nx      = idx_q;
        tg_load     = 1'b0;
        tg_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && !wrong) begin
                    state_nx = RUN;
                    tg_load  = 1'b1;
                end
            end
            RUN: begin
                if (wrong) begin
                    state_nx = DONE;
                end else begin
                    tg_en    = 1'b1;
                    state_nx = bus.enable ? RUN : PAUSE;
                    if (tc) begin
                        clk_slow_nx = !clk_slow_q;
                        tick_nx     = 1'b1;
                        idx_nx      = idx_q + IDX_W'(1);
                        if (last) begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (wrong) begin
                    state_nx = DONE;
                end else if (bus.enable) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                state_nx = DONE;
            end
        endcase
    end

    assign bus.clk_slow = clk_slow_q;
    assign bus.tick     = tick_q;
    assign bus.half_idx = idx_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: vector table, directed sequences
// and randomized stimulus against a behavioural model.
module tb_round_timer;

    localparam int CW = 32;
    localparam int IW = 5;
    localparam int WW = 3;
    localparam int DEF_LEN = 5;
    localparam int MAXH = 6;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    round_timer_if #(.CNT_W(CW), .IDX_W(IW), .WRONG_W(WW)) bus ();

    round_timer #(
        .HALF_CYC_DEF (DEF_LEN),
        .CNT_W        (CW),
        .MAX_HALVES   (MAXH),
        .IDX_W        (IW),
        .WRONG_W      (WW),
        .WRONG_LIMIT  (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int m_elapsed = 0;
    int m_len = 0;
    int m_halves = 0;
    bit m_tick = 0;

    // Model: a round is MAXH halves, each m_len cycles spent in RUN.
    task automatic model_step();
        bit stop;
        m_tick = 0;
        if (!rst_n || bus.clear) begin
            m_mode = M_IDLE;
            m_elapsed = 0;
            m_halves = 0;
            return;
        end
        stop = int'(bus.wrong_cnt) >= LIMIT;
        case (m_mode)
            M_IDLE: if (bus.enable && !stop) begin
                m_mode = M_RUN;
                m_elapsed = 0;
                m_len = (bus.half_cyc == 0) ? DEF_LEN : int'(bus.half_cyc);
            end
            M_RUN: if (stop) begin
                m_mode = M_DONE;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_len) begin
                    m_elapsed = 0;
                    m_halves++;
                    m_tick = 1;
                    m_len = (bus.half_cyc == 0) ? DEF_LEN : int'(bus.half_cyc);
                end
                if (m_halves == MAXH) m_mode = M_DONE;
                else if (!bus.enable) m_mode = M_PAUSE;
            end
            M_PAUSE: if (stop) m_mode = M_DONE;
                     else if (bus.enable) m_mode = M_RUN;
            default: ;
        endcase
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.clk_slow, bus.tick, bus.half_idx, bus.running, bus.done};
    endfunction

    function automatic logic [8:0] pack(bit cs, bit tk, int idx, bit rn, bit dn);
        logic [4:0] i5;
        i5 = idx[4:0];
        return {cs, tk, i5, rn, dn};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        model_step();
        #1;
        if (chk) begin
            check_val("model", int'(dut_vec()),
                      int'(pack(m_halves[0], m_tick, m_halves,
                                m_mode == M_RUN, m_mode == M_DONE)));
        end
    endtask

    task automatic restart();
        rst_n = 0;
        bus.enable = 0;
        bus.clear = 0;
        bus.wrong_cnt = 0;
        bus.half_cyc = 4;
        step(1);
        rst_n = 1;
    endtask

    int tq[$];

    task automatic collect(input int n);
        tq.delete();
        for (int e = 1; e <= n; e++) begin
            step(1);
            if (bus.tick) tq.push_back(e);
        end
    endtask

    task automatic check_ticks(input string name, input int first, input int gap, input int cnt);
        check_val({name, "_count"}, tq.size(), cnt);
        for (int k = 0; k < tq.size() && k < cnt; k++)
            check_val({name, "_pos"}, tq[k], first + gap * k);
    endtask

    typedef struct {
        bit rn; bit en; bit clr; int hc; int wc;
        bit cs; bit tk; int idx; bit run; bit dn;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit rn, bit en, bit clr, int hc, int wc,
                                bit cs, bit tk, int idx, bit run, bit dn);
        vec_t v;
        v.rn = rn; v.en = en; v.clr = clr; v.hc = hc; v.wc = wc;
        v.cs = cs; v.tk = tk; v.idx = idx; v.run = run; v.dn = dn;
        return v;
    endfunction

    initial begin
        bus.enable = 0;
        bus.clear = 0;
        bus.half_cyc = 4;
        bus.wrong_cnt = 0;

        tbl[0]  = mk(0,0,0,2,0, 0,0,0,0,0);
        tbl[1]  = mk(1,1,0,2,0, 0,0,0,1,0);
        tbl[2]  = mk(1,1,0,2,0, 0,0,0,1,0);
        tbl[3]  = mk(1,1,0,2,0, 1,1,1,1,0);
        tbl[4]  = mk(1,1,0,2,0, 1,0,1,1,0);
        tbl[5]  = mk(1,0,0,2,0, 0,1,2,0,0);
        tbl[6]  = mk(1,0,0,2,0, 0,0,2,0,0);
        tbl[7]  = mk(1,1,0,2,0, 0,0,2,1,0);
        tbl[8]  = mk(1,1,0,2,3, 0,0,2,0,1);
        tbl[9]  = mk(1,1,0,2,0, 0,0,2,0,1);
        tbl[10] = mk(1,0,1,2,0, 0,0,0,0,0);
        tbl[11] = mk(1,1,1,2,0, 0,0,0,0,0);
        tbl[12] = mk(1,1,0,1,0, 0,0,0,1,0);
        tbl[13] = mk(1,1,0,1,0, 1,1,1,1,0);
        tbl[14] = mk(1,1,0,1,0, 0,1,2,1,0);
        tbl[15] = mk(1,0,1,1,0, 0,0,0,0,0);
        tbl[16] = mk(1,1,0,1,4, 0,0,0,0,0);
        tbl[17] = mk(1,1,0,1,2, 0,0,0,1,0);

        // Reset then idle with enable low.
        restart();
        rst_n = 0;
        step(1);
        rst_n = 1;
        check_val("reset", int'(dut_vec()), 0);
        for (int i = 0; i < 10; i++) step(1);
        check_val("idle", int'(dut_vec()), 0);

        // Full round at half_cyc=4.
        bus.enable = 1;
        step(1);
        collect(44);
        check_ticks("full", 4, 4, MAXH);
        check_val("full_end", int'(dut_vec()), int'(pack(0,0,MAXH,0,1)));

        // Pause for 5 cycles from RUN cycle 6.
        restart();
        bus.enable = 1;
        step(1);
        tq.delete();
        for (int e = 1; e <= 20; e++) begin
            bus.enable = (e >= 6 && e <= 10) ? 1'b0 : 1'b1;
            step(1);
            if (bus.tick) tq.push_back(e);
            if (e == 9) check_val("pause_hold", int'(dut_vec()), int'(pack(1,0,1,0,0)));
        end
        check_val("pause_t1", tq.size() > 0 ? tq[0] : -1, 4);
        check_val("pause_t2", tq.size() > 1 ? tq[1] : -1, 13);

        // Wrong limit when cnt==3 beats the terminal count.
        restart();
        bus.enable = 1;
        step(1);
        for (int e = 1; e <= 3; e++) step(1);
        bus.wrong_cnt = 3;
        step(1);
        check_val("wrong_stop", int'(dut_vec()), int'(pack(0,0,0,0,1)));
        for (int e = 0; e < 5; e++) step(1);

        // Half period changed mid-half.
        restart();
        bus.enable = 1;
        step(1);
        step(1);
        bus.half_cyc = 2;
        tq.delete();
        for (int e = 2; e <= 20; e++) begin
            step(1);
            if (bus.tick) tq.push_back(e);
        end
        check_ticks("reperiod", 4, 2, MAXH);

        // half_cyc=0 selects the default length.
        restart();
        bus.half_cyc = 0;
        bus.enable = 1;
        step(1);
        collect(40);
        check_ticks("default", DEF_LEN, DEF_LEN, MAXH);

        // Clear mid-run, then reset while done.
        restart();
        bus.enable = 1;
        step(1);
        for (int e = 1; e <= 12; e++) step(1);
        check_val("pre_clear", int'(dut_vec()), int'(pack(1,1,3,1,0)));
        bus.clear = 1;
        step(1);
        check_val("clear", int'(dut_vec()), 0);
        bus.clear = 0;
        step(1);
        for (int e = 1; e <= 30; e++) step(1);
        check_val("pre_rst", int'(bus.done), 1);
        rst_n = 0;
        step(1);
        check_val("rst_done", int'(dut_vec()), 0);
        rst_n = 1;

        // Vector table.
        foreach (tbl[i]) begin
            rst_n = tbl[i].rn;
            bus.enable = tbl[i].en;
            bus.clear = tbl[i].clr;
            bus.half_cyc = tbl[i].hc;
            bus.wrong_cnt = tbl[i].wc[WW-1:0];
            step(0);
            check_val($sformatf("tbl%0d", i), int'(dut_vec()),
                      int'(pack(tbl[i].cs, tbl[i].tk, tbl[i].idx,
                                tbl[i].run, tbl[i].dn)));
        end

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            bus.clear = ($urandom_range(0, 99) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.half_cyc = $urandom_range(0, 4);
            bus.wrong_cnt = ($urandom_range(0, 49) == 0) ?
                            WW'($urandom_range(3, 7)) : WW'($urandom_range(0, 2));
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
